// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - core reset sequencer and clock-enable gate (idle / counted burst / free-run)
// Optional trace counter on cycles_o is built when STEP_CTRL_TRACE_EN is defined.
module step_ctrl #(
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned BURST_DEF  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sreq_i,
   input  logic             halt_i,
   input  logic             run_i,
   input  logic             step_i,
   input  logic [CNT_W-1:0] step_count_i,
   output logic             cpu_rst_o,
   output logic             cpu_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [31:0]      cycles_o
);

   localparam int unsigned      RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] BURST_LD = CNT_W'(BURST_DEF);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_IDLE,
      ST_BURST,
      ST_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [RC_W-1:0]  rcnt_q, rcnt_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;
   logic             cpu_rst_q, cpu_en_q, busy_q, done_q, done_d;

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      bcnt_d  = bcnt_q;
      done_d  = 1'b0;
      if (sreq_i) begin
         // An aborted burst or run ends silently: no done pulse.
         state_d = ST_RESET;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            ST_RESET: begin
               if (rcnt_q == RC_LAST) state_d = ST_IDLE;
               else                   rcnt_d  = rcnt_q + 1'b1;
            end
            ST_IDLE: begin
               if (run_i) begin
                  state_d = ST_RUN;
               end else if (step_i) begin
                  state_d = ST_BURST;
                  bcnt_d  = (step_count_i == '0) ? BURST_LD : step_count_i;
               end
            end
            ST_BURST: begin
               // bcnt_q holds the enables still owed, including the current cycle.
               if (halt_i || (bcnt_q == CNT_W'(1))) begin
                  state_d = ST_IDLE;
                  bcnt_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  bcnt_d  = bcnt_q - 1'b1;
               end
            end
            ST_RUN: begin
               if (halt_i || !run_i) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RESET;
         rcnt_q    <= '0;
         bcnt_q    <= '0;
         cpu_rst_q <= 1'b1;
         cpu_en_q  <= 1'b0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         bcnt_q    <= bcnt_d;
         cpu_rst_q <= (state_d == ST_RESET);
         cpu_en_q  <= (state_d == ST_BURST) || (state_d == ST_RUN);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= done_d;
      end
   end

   assign cpu_rst_o = cpu_rst_q;
   assign cpu_en_o  = cpu_en_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

`ifdef STEP_CTRL_TRACE_EN
   logic [31:0] cycles_q, cycles_d;

   always_comb begin
      cycles_d = cycles_q;
      if (sreq_i)
         cycles_d = '0;
      else if (cpu_en_q && (cycles_q != 32'hFFFF_FFFF))
         cycles_d = cycles_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cycles_q <= '0;
      else      cycles_q <= cycles_d;
   end

   assign cycles_o = cycles_q;
`else
   assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - self-checking bench for step_ctrl (cycle model plus directed literal checks)
module tb_step_ctrl;
   localparam int CNT_W      = 16;
   localparam int RST_CYCLES = 2;
   localparam int BURST_DEF  = 3;
`ifdef STEP_CTRL_TRACE_EN
   localparam bit TRACE = 1'b1;
`else
   localparam bit TRACE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sreq = 1'b0, halt = 1'b0, run = 1'b0, step = 1'b0;
   logic [CNT_W-1:0] step_count = '0;
   logic             cpu_rst, cpu_en, busy, done;
   logic [31:0]      cycles;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   step_ctrl #(.RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W), .BURST_DEF(BURST_DEF)) dut (
      .clk(clk), .rst(rst), .sreq_i(sreq), .halt_i(halt), .run_i(run), .step_i(step),
      .step_count_i(step_count), .cpu_rst_o(cpu_rst), .cpu_en_o(cpu_en), .busy_o(busy),
      .done_o(done), .cycles_o(cycles)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: tracks mode plus the absolute edge number at which the current reset or burst ends.
   localparam int M_RESET = 0, M_IDLE = 1, M_BURST = 2, M_RUN = 3;
   int          m_mode   = M_RESET;
   logic [31:0] cyc      = 32'd0;
   logic [31:0] r_end    = 32'(RST_CYCLES);
   logic [31:0] b_end    = 32'd0;
   logic [31:0] m_cycles = 32'd0;
   logic        m_done   = 1'b0;
   logic [31:0] now;
   assign now = cyc + 32'd1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode   <= M_RESET;
         r_end    <= cyc + 32'(RST_CYCLES);
         m_done   <= 1'b0;
         m_cycles <= 32'd0;
      end else begin
         cyc    <= now;
         m_done <= 1'b0;
         if (TRACE && (m_mode == M_BURST || m_mode == M_RUN) && m_cycles != 32'hFFFF_FFFF)
            m_cycles <= m_cycles + 32'd1;
         if (sreq) begin
            m_mode   <= M_RESET;
            r_end    <= now + 32'(RST_CYCLES);
            m_cycles <= 32'd0;
         end else begin
            case (m_mode)
               M_RESET: if (now == r_end) m_mode <= M_IDLE;
               M_IDLE: begin
                  if (run) m_mode <= M_RUN;
                  else if (step) begin
                     m_mode <= M_BURST;
                     b_end  <= now + ((step_count == '0) ? 32'(BURST_DEF) : 32'(step_count));
                  end
               end
               M_BURST: if (halt || now == b_end) begin m_mode <= M_IDLE; m_done <= 1'b1; end
               M_RUN:   if (halt || !run)         begin m_mode <= M_IDLE; m_done <= 1'b1; end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_mode == M_RESET});
      chk("cpu_en",  {31'd0, cpu_en},  {31'd0, (m_mode == M_BURST) || (m_mode == M_RUN)});
      chk("busy",    {31'd0, busy},    {31'd0, m_mode != M_IDLE});
      chk("done",    {31'd0, done},    {31'd0, m_done});
      chk("cycles",  cycles,           TRACE ? m_cycles : 32'd0);
   end

   initial begin
      int hi, ens, dn;

      repeat (3) @(negedge clk);
      chk("lit_reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("lit_reset_busy",    {31'd0, busy},    32'd1);
      chk("lit_reset_en",      {31'd0, cpu_en},  32'd0);
      chk("lit_reset_cycles",  cycles,           32'd0);

      // Release reset; count the rising edges that still see cpu_rst high.
      rst = 1'b1;
      hi  = 0;
      for (int m = 1; m <= 5; m++) begin
         if (cpu_rst) hi++;
         @(negedge clk);
      end
      chk("lit_release_len", hi, 32'd2);
      chk("lit_release_busy", {31'd0, busy}, 32'd0);

      // Default burst, step_count 0 -> 3 enables
      step = 1'b1; step_count = '0;
      @(negedge clk);
      step = 1'b0; ens = 0; dn = 0;
      for (int i = 0; i < 8; i++) begin
         if (cpu_en) ens++;
         if (done) dn++;
         @(negedge clk);
      end
      chk("lit_def_burst_en", ens, 32'd3);
      chk("lit_def_burst_done", dn, 32'd1);
      chk("lit_def_burst_cycles", cycles, TRACE ? 32'd3 : 32'd0);

      // Burst of 10 halted on the 4th enabled cycle
      step = 1'b1; step_count = 16'd10;
      @(negedge clk);
      step = 1'b0; ens = 0; dn = 0;
      for (int i = 0; i < 12; i++) begin
         if (cpu_en) ens++;
         if (done) dn++;
         halt = (ens == 4) && cpu_en;
         @(negedge clk);
      end
      halt = 1'b0;
      chk("lit_halt_en", ens, 32'd4);
      chk("lit_halt_done", dn, 32'd1);
      chk("lit_halt_busy", {31'd0, busy}, 32'd0);
      chk("lit_halt_cycles", cycles, TRACE ? 32'd7 : 32'd0);

      // Step with halt held in IDLE still starts a burst
      halt = 1'b1; step = 1'b1; step_count = 16'd2;
      @(negedge clk);
      halt = 1'b0; step = 1'b0;
      chk("lit_step_halt_starts", {31'd0, cpu_en}, 32'd1);
      repeat (4) @(negedge clk);

      // Back-to-back bursts of 2 with step held high
      step = 1'b1; step_count = 16'd2;
      @(negedge clk);
      ens = 0; dn = 0;
      for (int i = 0; i < 8; i++) begin
         if (cpu_en) ens++;
         if (done) dn++;
         @(negedge clk);
      end
      step = 1'b0;
      repeat (4) @(negedge clk);
      chk("lit_b2b_en", ens, 32'd6);
      chk("lit_b2b_done", dn, 32'd2);

      // Free-run for 20 cycles while step toggles
      run = 1'b1; ens = 0; dn = 0;
      for (int i = 0; i < 20; i++) begin
         step = i[0];
         @(negedge clk);
         if (cpu_en) ens++;
         if (done) dn++;
      end
      run = 1'b0; step = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (cpu_en) ens++;
         if (done) dn++;
      end
      chk("lit_run_en", ens, 32'd20);
      chk("lit_run_done", dn, 32'd1);
      chk("lit_run_cycles", cycles, TRACE ? 32'd35 : 32'd0);

      // Soft reset in the middle of a 100-cycle burst
      step = 1'b1; step_count = 16'd100;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      sreq = 1'b1;
      @(negedge clk);
      sreq = 1'b0;
      chk("lit_sreq_en_off", {31'd0, cpu_en}, 32'd0);
      chk("lit_sreq_cycles", cycles, 32'd0);
      hi = 0; dn = 0;
      for (int i = 0; i < 6; i++) begin
         if (cpu_rst) hi++;
         if (done) dn++;
         @(negedge clk);
      end
      chk("lit_sreq_rst_len", hi, 32'd2);
      chk("lit_sreq_no_done", dn, 32'd0);

      // Asynchronous reset between clock edges during a run
      run = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("lit_async_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("lit_async_en",      {31'd0, cpu_en},  32'd0);
      chk("lit_async_busy",    {31'd0, busy},    32'd1);
      chk("lit_async_done",    {31'd0, done},    32'd0);
      chk("lit_async_cycles",  cycles,           32'd0);
      run = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("lit_async_recover", {31'd0, cpu_rst}, 32'd0);

      // Single-cycle burst
      step = 1'b1; step_count = 16'd1;
      @(negedge clk);
      step = 1'b0; ens = 0; dn = 0;
      for (int i = 0; i < 5; i++) begin
         if (cpu_en) ens++;
         if (done) dn++;
         @(negedge clk);
      end
      chk("lit_n1_en", ens, 32'd1);
      chk("lit_n1_done", dn, 32'd1);
      chk("lit_n1_cycles", cycles, TRACE ? 32'd1 : 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
